// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences single CPU read/write requests onto an asynchronous RAM
// with wait-stated strobes, write setup/hold cycles and conflict rejection.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [8:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        read,
  output logic        write,
  output logic [8:0]  address,
  output logic [31:0] BusMuxOut,
  input  logic [31:0] Mdatain
);
  typedef enum logic [2:0] {IDLE, RD, WSETUP, WR, WHOLD, DONE} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        read_q, write_q, busy_q, done_q, err_q, err_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE:
        if (req_rd && req_wr) err_d = 1'b1;
        else if (req_rd || req_wr) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WC;
          state_d = req_rd ? RD : WSETUP;
        end
      RD:
        if (cnt_q == 4'd0) begin
          rdata_d = Mdatain;
          state_d = DONE;
        end else cnt_d = cnt_q - 4'd1;
      // WR is held WAIT_CYCLES cycles, so it counts down from one less
      WSETUP: begin
        cnt_d   = WC - 4'd1;
        state_d = WR;
      end
      WR: begin
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? WHOLD : WR;
      end
      WHOLD:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Strobes and flags are decoded from the next state so every output is a flop.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 9'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      read_q  <= state_d == RD;
      write_q <= state_d == WR;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      err_q   <= err_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign read      = read_q;
  assign write     = write_q;
  assign address   = addr_q;
  assign BusMuxOut = wdata_q;
endmodule
